// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front end.
//   Issues one icache request at a time and buffers returned instructions in a
//   small FIFO for decode. It handles icache misses, where the icache retries
//   internally while ic_pc is held, and redirects (branch/jump/trap), which
//   flush the buffer and restart fetch.
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   redirect_valid_i  flush and restart fetch at redirect_pc_i
//   redirect_pc_i     new fetch address
//   ic_pc_o, ic_req_o fetch address / request strobe to the icache
//   ic_inst_i         instruction word returned by the icache
//   ic_valid_i        response status; 0 means miss
//   id_valid_o        head of buffer is valid
//   id_ready_i        decode accepts the head
//   id_inst_o         head instruction word
//   id_pc_o           head instruction address
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int unsigned QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] ic_pc_o,
  output logic        ic_req_o,
  input  logic [31:0] ic_inst_i,
  input  logic        ic_valid_i,
  output logic        id_valid_o,
  input  logic        id_ready_i,
  output logic [31:0] id_inst_o,
  output logic [31:0] id_pc_o
);

  localparam int unsigned AW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

  typedef enum logic [1:0] {BOOT, IDLE, RUN, MISS} state_t;

  state_t      state_q, state_d;
  logic [31:0] fpc_q, fpc_d;   // address of the outstanding / next request
  logic [31:0] spc_q, spc_d;   // redirect target held while a killed miss drains
  logic        kill_q, kill_d;
  logic [31:0] nxt_pc;

  logic [31:0] buf_inst_q [QDEPTH];
  logic [31:0] buf_pc_q   [QDEPTH];
  logic [AW-1:0] rd_q, wr_q;
  logic [AW:0]   cnt_q, cnt_after;

  logic busy, push, pop, flush, credit;

  assign busy  = (state_q == RUN) || (state_q == MISS);
  assign flush = redirect_valid_i;

  assign id_valid_o = !rst && (cnt_q != '0);
  assign id_inst_o  = buf_inst_q[rd_q];
  assign id_pc_o    = buf_pc_q[rd_q];

  assign pop  = id_valid_o && id_ready_i;
  assign push = busy && ic_valid_i && !kill_q && !redirect_valid_i;

  // Occupancy after this cycle's push/pop decides whether a new request may
  // go out; the response lands next cycle, so this bound prevents overflow.
  assign cnt_after = cnt_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
  assign credit    = cnt_after < (AW+1)'(QDEPTH);

  // ic_pc is combinational so a returning hit can issue its successor in the
  // same cycle, sustaining one instruction per cycle.
  assign ic_pc_o = rst ? RESET_PC : nxt_pc;

  always_comb begin
    state_d  = state_q;
    fpc_d    = fpc_q;
    spc_d    = spc_q;
    kill_d   = kill_q;
    nxt_pc   = fpc_q;
    ic_req_o = 1'b0;
    if (redirect_valid_i) begin
      if (busy && !ic_valid_i) begin
        // icache is still retrying fpc_q: let it finish, drop its result later
        spc_d   = redirect_pc_i;
        kill_d  = 1'b1;
        state_d = MISS;
      end else begin
        fpc_d   = redirect_pc_i;
        kill_d  = 1'b0;
        state_d = IDLE;
      end
    end else begin
      case (state_q)
        BOOT, IDLE: begin
          if (credit) begin
            ic_req_o = 1'b1;
            state_d  = RUN;
          end else begin
            state_d  = IDLE;
          end
        end
        RUN, MISS: begin
          if (!ic_valid_i) begin
            state_d = MISS;
          end else if (kill_q) begin
            kill_d  = 1'b0;
            fpc_d   = spc_q;
            state_d = IDLE;
          end else begin
            nxt_pc = fpc_q + 32'd4;
            fpc_d  = nxt_pc;
            if (credit) begin
              ic_req_o = 1'b1;
              state_d  = RUN;
            end else begin
              state_d  = IDLE;
            end
          end
        end
        default: state_d = BOOT;
      endcase
    end
    if (rst) ic_req_o = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BOOT;
      fpc_q   <= RESET_PC;
      spc_q   <= RESET_PC;
      kill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      fpc_q   <= fpc_d;
      spc_q   <= spc_d;
      kill_q  <= kill_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_after;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      buf_inst_q[wr_q] <= ic_inst_i;
      buf_pc_q[wr_q]   <= fpc_q;
    end
  end

endmodule
